// File: rtl/bias_pwr_seq.sv
// Bias generator power sequencer: wake, confirm bias, enable amp then comparator.
// Reverse-order shutdown; sticky fault if bias never appears or collapses.
module bias_pwr_seq #(
    parameter int WAKE_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SETTLE_CYCLES  = 8,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_req,
    input  logic       bias_ok,
    output logic       pwdn,
    output logic       amp_en,
    output logic       cmp_en,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_WAKE   = 3'd1,
        S_CHECK  = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_SHUT1  = 3'd5,
        S_SHUT2  = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sync2;
    logic             bok;

    assign bok   = sync2;
    assign state = state_q;

    // Two-flop synchronizer for the asynchronous bias level detector
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bias_ok;
            sync2 <= sync1;
        end
    end

    // Sequencer FSM with registered outputs; counter only loaded or decremented when nonzero
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            cnt     <= '0;
            pwdn    <= 1'b1;
            amp_en  <= 1'b0;
            cmp_en  <= 1'b0;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (en_req) begin
                        state_q <= S_WAKE;
                        pwdn    <= 1'b0;
                        cnt     <= WAKE_LD;
                    end
                end
                S_WAKE: begin
                    if (!en_req) begin
                        state_q <= S_OFF;
                        pwdn    <= 1'b1;
                        amp_en  <= 1'b0;
                    end else if (cnt == '0) begin
                        state_q <= S_CHECK;
                        cnt     <= TMO_LD;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                S_CHECK: begin
                    if (!en_req) begin
                        state_q <= S_OFF;
                        pwdn    <= 1'b1;
                        amp_en  <= 1'b0;
                    end else if (bok) begin
                        state_q <= S_SETTLE;
                        amp_en  <= 1'b1;
                        cnt     <= SET_LD;
                    end else if (cnt == '0) begin
                        state_q <= S_FAULT;
                        pwdn    <= 1'b1;
                        amp_en  <= 1'b0;
                        fault   <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                S_SETTLE: begin
                    if (!bok) begin
                        state_q <= S_FAULT;
                        pwdn    <= 1'b1;
                        amp_en  <= 1'b0;
                        fault   <= 1'b1;
                    end else if (!en_req) begin
                        state_q <= S_OFF;
                        pwdn    <= 1'b1;
                        amp_en  <= 1'b0;
                    end else if (cnt == '0) begin
                        state_q <= S_RUN;
                        cmp_en  <= 1'b1;
                        ready   <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                S_RUN: begin
                    if (!bok) begin
                        state_q <= S_FAULT;
                        pwdn    <= 1'b1;
                        amp_en  <= 1'b0;
                        cmp_en  <= 1'b0;
                        ready   <= 1'b0;
                        fault   <= 1'b1;
                    end else if (!en_req) begin
                        state_q <= S_SHUT1;
                        cmp_en  <= 1'b0;
                        ready   <= 1'b0;
                    end
                end
                S_SHUT1: begin
                    state_q <= S_SHUT2;
                    amp_en  <= 1'b0;
                end
                S_SHUT2: begin
                    state_q <= S_OFF;
                    pwdn    <= 1'b1;
                end
                S_FAULT: begin
                    if (!en_req) begin
                        state_q <= S_OFF;
                        fault   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_OFF;
                    pwdn    <= 1'b1;
                    amp_en  <= 1'b0;
                    cmp_en  <= 1'b0;
                    ready   <= 1'b0;
                    fault   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_pwr_seq.sv
// Bench for bias_pwr_seq: directed sequences plus random stimulus against a phase model.
// Two instances run side by side: default timing and all-ones timing.
module tb_bias_pwr_seq;

    localparam int P_OFF = 0, P_WAKE = 1, P_CHECK = 2, P_SETTLE = 3;
    localparam int P_RUN = 4, P_SHUT1 = 5, P_SHUT2 = 6, P_FAULT = 7;

    localparam int WK[2] = '{16, 1};
    localparam int TO[2] = '{64, 1};
    localparam int ST[2] = '{8, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_req = 1'b0;
    logic bias_ok = 1'b0;

    logic       pwdn0, amp0, cmp0, rdy0, flt0;
    logic [2:0] st0;
    logic       pwdn1, amp1, cmp1, rdy1, flt1;
    logic [2:0] st1;
    logic [7:0] obs0, obs1;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    int ph[2] = '{0, 0};
    int el[2] = '{0, 0};
    bit b1 = 1'b0;
    bit b2 = 1'b0;

    always #5 clk = ~clk;

    bias_pwr_seq dut0 (
        .clk(clk), .rst(rst), .en_req(en_req), .bias_ok(bias_ok),
        .pwdn(pwdn0), .amp_en(amp0), .cmp_en(cmp0), .ready(rdy0),
        .fault(flt0), .state(st0)
    );

    bias_pwr_seq #(
        .WAKE_CYCLES(1), .TIMEOUT_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(8)
    ) dut1 (
        .clk(clk), .rst(rst), .en_req(en_req), .bias_ok(bias_ok),
        .pwdn(pwdn1), .amp_en(amp1), .cmp_en(cmp1), .ready(rdy1),
        .fault(flt1), .state(st1)
    );

    assign obs0 = {st0, pwdn0, amp0, cmp0, rdy0, flt0};
    assign obs1 = {st1, pwdn1, amp1, cmp1, rdy1, flt1};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      tag, obs, exp, $time);
    endtask

    // Output word {state, pwdn, amp_en, cmp_en, ready, fault} per phase
    function automatic logic [7:0] exp_out(input int p);
        case (p)
            P_OFF:    return 8'b000_10000;
            P_WAKE:   return 8'b001_00000;
            P_CHECK:  return 8'b010_00000;
            P_SETTLE: return 8'b011_01000;
            P_RUN:    return 8'b100_01110;
            P_SHUT1:  return 8'b101_01000;
            P_SHUT2:  return 8'b110_00000;
            default:  return 8'b111_10001;
        endcase
    endfunction

    function automatic logic inv_ok(input logic [7:0] o);
        logic pd, am, cm, rd, ft;
        {pd, am, cm, rd, ft} = o[4:0];
        return (!rd || (cm && am && !pd)) && (!cm || am) &&
               (!am || !pd) && (!ft || pd);
    endfunction

    // Phase model: el counts cycles already spent in a timed phase
    function automatic void step(input int i);
        int p = ph[i];
        int e = el[i];
        case (p)
            P_OFF: if (en_req) begin p = P_WAKE; e = 0; end
            P_WAKE: begin
                if (!en_req) p = P_OFF;
                else if (e == WK[i] - 1) begin p = P_CHECK; e = 0; end
                else e++;
            end
            P_CHECK: begin
                if (!en_req) p = P_OFF;
                else if (b2) begin p = P_SETTLE; e = 0; end
                else if (e == TO[i] - 1) p = P_FAULT;
                else e++;
            end
            P_SETTLE: begin
                if (!b2) p = P_FAULT;
                else if (!en_req) p = P_OFF;
                else if (e == ST[i] - 1) p = P_RUN;
                else e++;
            end
            P_RUN: begin
                if (!b2) p = P_FAULT;
                else if (!en_req) p = P_SHUT1;
            end
            P_SHUT1: p = P_SHUT2;
            P_SHUT2: p = P_OFF;
            default: if (!en_req) p = P_OFF;
        endcase
        ph[i] = p;
        el[i] = e;
    endfunction

    // Advance the reference model on each active edge
    always @(posedge clk) begin
        if (rst) begin
            ph = '{P_OFF, P_OFF};
            el = '{0, 0};
            b1 = 1'b0;
            b2 = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) step(i);
            b2 = b1;
            b1 = bias_ok;
        end
    end

    // Compare both instances against the model and invariants every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dut0_outs", obs0, exp_out(ph[0]));
            chk("dut1_outs", obs1, exp_out(ph[1]));
            chk("dut0_inv", inv_ok(obs0), 1);
            chk("dut1_inv", inv_ok(obs1), 1);
        end
    end

    function automatic logic sig0(input int sel);
        case (sel)
            0: return pwdn0;
            1: return amp0;
            2: return cmp0;
            3: return rdy0;
            default: return flt0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel, input logic val,
                            input int maxc, output int n);
        n = 0;
        while (sig0(sel) !== val && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (sig0(sel) !== val) chk(tag, sig0(sel), val);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en_req = 1'b0;
        bias_ok = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_state", obs0, 8'b000_10000);
        do_reset();

        // Nominal power-up
        en_req = 1'b1;
        bias_ok = 1'b1;
        wait_sig("s1_pwdn_to", 0, 1'b0, 10, n);
        chk("s1_pwdn_lat", n, 1);
        wait_sig("s1_amp_to", 1, 1'b1, 100, n);
        chk("s1_amp_lat", n, 17);
        wait_sig("s1_cmp_to", 2, 1'b1, 100, n);
        chk("s1_cmp_lat", n, 8);
        chk("s1_ready", rdy0, 1);

        // Bias collapse in RUN
        bias_ok = 1'b0;
        wait_sig("s3_fault_to", 4, 1'b1, 20, n);
        chk("s3_fault_lat", n, 3);
        chk("s3_outs", obs0, 8'b111_10001);
        en_req = 1'b0;
        @(negedge clk);
        chk("s3_clear", obs0, 8'b000_10000);

        // Bias never appears
        do_reset();
        en_req = 1'b1;
        wait_sig("s2_pwdn_to", 0, 1'b0, 10, n);
        wait_sig("s2_fault_to", 4, 1'b1, 200, n);
        chk("s2_fault_lat", n, 80);
        repeat (5) @(negedge clk);
        chk("s2_sticky", obs0, 8'b111_10001);
        en_req = 1'b0;
        @(negedge clk);
        chk("s2_clear", obs0, 8'b000_10000);

        // Ordered shutdown with a glitch on en_req
        do_reset();
        en_req = 1'b1;
        bias_ok = 1'b1;
        wait_sig("s4_ready_to", 3, 1'b1, 100, n);
        en_req = 1'b0;
        @(negedge clk);
        chk("s4_shut1", obs0, 8'b101_01000);
        en_req = 1'b1;
        @(negedge clk);
        chk("s4_shut2", obs0, 8'b110_00000);
        en_req = 1'b0;
        @(negedge clk);
        chk("s4_off", obs0, 8'b000_10000);

        // Abort during WAKE, then reset during SETTLE
        do_reset();
        en_req = 1'b1;
        bias_ok = 1'b1;
        repeat (5) @(negedge clk);
        chk("s5_in_wake", st0, 1);
        en_req = 1'b0;
        @(negedge clk);
        chk("s5_abort", obs0, 8'b000_10000);
        en_req = 1'b1;
        wait_sig("s5_amp_to", 1, 1'b1, 100, n);
        chk("s5_settle", st0, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("s5_rst0", obs0, 8'b000_10000);
        chk("s5_rst1", obs1, 8'b000_10000);
        rst = 1'b0;
        en_req = 1'b0;

        // Random traffic against the model
        bias_ok = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) en_req = ~en_req;
            if (bias_ok && $urandom_range(0, 99) == 0) bias_ok = 1'b0;
            else if (!bias_ok && $urandom_range(0, 4) == 0) bias_ok = 1'b1;
            rst = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
